fifo_sync_ext: RTL and testbench

- Parametrised synchronous FIFO; next generation of the team's single-clock FIFO.
- Supports arbitrary (non-power-of-2) depth, with explicit pointer wrap.
- Selectable output mode: registered standard read or first-word-fall-through (FWFT).
- Adds programmable almost-full/almost-empty thresholds, an occupancy output, sticky overflow/underflow flags, and exact count handling on simultaneous read+write.
- Sits between producer/consumer stages in the datapath as the standard elastic buffer.

---
 rtl/fifo_sync_ext_if.sv | 33 +++
 rtl/fifo_sync_ext.sv | 125 ++++++++++++
 tb/tb_fifo_sync_ext.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_ext_if.sv
// Producer/consumer-facing bundle of the fifo_sync_ext elastic buffer.
// The FIFO takes the slave modport; the stage driving it uses master.
interface fifo_sync_ext_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 10,
   parameter int ADD_W  = $clog2(DEPTH)
);
   logic              wr_en;
   logic [DATA_W-1:0] din;
   logic              rd_en;
   logic              clr_err;
   logic [DATA_W-1:0] dout;
   logic              valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADD_W:0]    level;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, din, rd_en, clr_err,
      input  dout, valid, full, empty, almost_full, almost_empty,
             level, overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en, clr_err,
      output dout, valid, full, empty, almost_full, almost_empty,
             level, overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read port,
// programmable almost-full/empty thresholds and sticky error flags.
module fifo_sync_ext #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 10,
   parameter int FWFT      = 0,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int ADD_W     = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   fifo_sync_ext_if.slave bus
);

   if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_sync_ext: DEPTH must be >= 2");
   end
   if (ADD_W != $clog2(DEPTH)) begin : g_bad_addw
      $error("fifo_sync_ext: ADD_W is derived from DEPTH and must not be overridden");
   end
   if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_sync_ext: AF_THRESH must lie in 0..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
      $error("fifo_sync_ext: AE_THRESH must lie in 0..DEPTH");
   end

   localparam logic [ADD_W-1:0] PTR_LAST = ADD_W'(DEPTH - 1);
   localparam logic [ADD_W:0]   LVL_FULL = (ADD_W+1)'(DEPTH);
   localparam logic [ADD_W:0]   LVL_AF   = (ADD_W+1)'(AF_THRESH);
   localparam logic [ADD_W:0]   LVL_AE   = (ADD_W+1)'(AE_THRESH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADD_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADD_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [ADD_W:0]    level_q, level_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              full, empty;
   logic              wr_acc, rd_acc;

   always_comb begin
      full        = (level_q == LVL_FULL);
      empty       = (level_q == '0);
      // Acceptance uses the pre-edge level only: a read never frees room
      // for a same-cycle write, and a write never feeds a same-cycle read.
      wr_acc      = bus.wr_en & ~full;
      rd_acc      = bus.rd_en & ~empty;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = (overflow_q  & ~bus.clr_err) | (bus.wr_en & full);
      underflow_d = (underflow_q & ~bus.clr_err) | (bus.rd_en & empty);

      if (wr_acc) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ADD_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ADD_W'(1);
      end

      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + (ADD_W+1)'(1);
         2'b01:   level_d = level_q - (ADD_W+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr_acc) begin
         mem_q[wr_ptr_q] <= bus.din;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; forced to zero while empty so the
      // port reads 0 after reset in both output modes.
      assign bus.dout  = empty ? '0 : mem_q[rd_ptr_q];
      assign bus.valid = ~empty;
   end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              valid_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
               dout_q <= mem_q[rd_ptr_q];
            end
         end
      end

      assign bus.dout  = dout_q;
      assign bus.valid = valid_q;
   end

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (level_q >= LVL_AF);
   assign bus.almost_empty = (level_q <= LVL_AE);
   assign bus.level        = level_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Directed bench for fifo_sync_ext: three instances cover standard mode at
// DEPTH=5, threshold flags at DEPTH=10 and first-word-fall-through at DEPTH=4.
module tb_fifo_sync_ext;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst5_n, rst10_n, rstf_n;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   fifo_sync_ext_if #(.DATA_W(8), .DEPTH(5))  b5  ();
   fifo_sync_ext_if #(.DATA_W(8), .DEPTH(10)) b10 ();
   fifo_sync_ext_if #(.DATA_W(8), .DEPTH(4))  bf  ();

   fifo_sync_ext #(.DATA_W(8), .DEPTH(5), .FWFT(0), .AF_THRESH(3), .AE_THRESH(2)) u_d5 (
      .clk(clk), .rst_n(rst5_n), .bus(b5)
   );
   fifo_sync_ext #(.DATA_W(8), .DEPTH(10), .FWFT(0), .AF_THRESH(8), .AE_THRESH(2)) u_d10 (
      .clk(clk), .rst_n(rst10_n), .bus(b10)
   );
   fifo_sync_ext #(.DATA_W(8), .DEPTH(4), .FWFT(1), .AF_THRESH(2), .AE_THRESH(1)) u_fw (
      .clk(clk), .rst_n(rstf_n), .bus(bf)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      b5.wr_en  = 1'b0; b5.rd_en  = 1'b0; b5.din  = '0; b5.clr_err  = 1'b0;
      b10.wr_en = 1'b0; b10.rd_en = 1'b0; b10.din = '0; b10.clr_err = 1'b0;
      bf.wr_en  = 1'b0; bf.rd_en  = 1'b0; bf.din  = '0; bf.clr_err  = 1'b0;
      rst5_n = 1'b0; rst10_n = 1'b0; rstf_n = 1'b0;
      step(); step();
      rst5_n = 1'b1; rst10_n = 1'b1; rstf_n = 1'b1;

      // Reset state
      chk("rst_level", b5.level, 0);
      chk("rst_empty", b5.empty, 1);
      chk("rst_full", b5.full, 0);
      chk("rst_valid", b5.valid, 0);
      chk("rst_dout", b5.dout, 0);
      chk("rst_ovf", b5.overflow, 0);
      chk("rst_udf", b5.underflow, 0);
      chk("rst_ae", b5.almost_empty, 1);
      chk("rst_af", b5.almost_full, 0);

      // Fill, overflow, drain
      for (int i = 0; i < 5; i++) begin
         b5.wr_en = 1'b1; b5.din = 8'(8'h11 + i);
         step();
         chk("fill_level", b5.level, i + 1);
      end
      b5.wr_en = 1'b0;
      chk("fill_full", b5.full, 1);
      chk("fill_af", b5.almost_full, 1);
      chk("fill_ae", b5.almost_empty, 0);
      b5.wr_en = 1'b1; b5.din = 8'hAA;
      step();
      b5.wr_en = 1'b0;
      chk("ovf_flag", b5.overflow, 1);
      chk("ovf_level", b5.level, 5);
      for (int i = 0; i < 5; i++) begin
         b5.rd_en = 1'b1;
         step();
         b5.rd_en = 1'b0;
         chk("rd_valid", b5.valid, 1);
         chk("rd_dout", b5.dout, 8'h11 + i);
         step();
         chk("rd_valid_drop", b5.valid, 0);
         chk("rd_dout_hold", b5.dout, 8'h11 + i);
      end
      chk("drain_empty", b5.empty, 1);
      chk("drain_level", b5.level, 0);
      chk("drain_udf", b5.underflow, 0);
      chk("ovf_sticky", b5.overflow, 1);
      b5.clr_err = 1'b1;
      step();
      b5.clr_err = 1'b0;
      chk("ovf_clr", b5.overflow, 0);

      // Pointer wrap: 4 rounds of write 3 / read 3
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 3; k++) begin
            b5.wr_en = 1'b1; b5.din = 8'(8'h20 + 3 * r + k);
            step();
         end
         b5.wr_en = 1'b0;
         chk("wrap_level", b5.level, 3);
         for (int k = 0; k < 3; k++) begin
            b5.rd_en = 1'b1;
            step();
            chk("wrap_valid", b5.valid, 1);
            chk("wrap_dout", b5.dout, 8'h20 + 3 * r + k);
         end
         b5.rd_en = 1'b0;
         step();
         chk("wrap_valid_drop", b5.valid, 0);
         chk("wrap_empty", b5.level, 0);
      end

      // Simultaneous read+write at level 2
      b5.wr_en = 1'b1; b5.din = 8'h30; step();
      b5.din = 8'h31; step();
      chk("sim_pre_level", b5.level, 2);
      for (int i = 0; i < 6; i++) begin
         b5.wr_en = 1'b1; b5.rd_en = 1'b1; b5.din = 8'(8'h32 + i);
         step();
         chk("sim_level", b5.level, 2);
         chk("sim_valid", b5.valid, 1);
         chk("sim_dout", b5.dout, 8'h30 + i);
      end
      b5.rd_en = 1'b0;
      b5.din = 8'h38; step();
      b5.din = 8'h39; step();
      b5.din = 8'h3A; step();
      chk("simfull_level", b5.level, 5);
      b5.rd_en = 1'b1; b5.din = 8'hBB;
      step();
      b5.wr_en = 1'b0;
      chk("simfull_level_after", b5.level, 4);
      chk("simfull_ovf", b5.overflow, 1);
      chk("simfull_dout", b5.dout, 8'h36);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("simfull_drain", b5.dout, 8'h37 + i);
      end
      b5.rd_en = 1'b0;
      step();
      chk("simfull_empty", b5.empty, 1);
      b5.clr_err = 1'b1; step(); b5.clr_err = 1'b0;
      chk("simfull_ovf_clr", b5.overflow, 0);
      b5.wr_en = 1'b1; b5.rd_en = 1'b1; b5.din = 8'h3C;
      step();
      b5.wr_en = 1'b0; b5.rd_en = 1'b0;
      chk("simempty_level", b5.level, 1);
      chk("simempty_udf", b5.underflow, 1);
      chk("simempty_valid", b5.valid, 0);
      b5.rd_en = 1'b1; step(); b5.rd_en = 1'b0;
      chk("simempty_dout", b5.dout, 8'h3C);
      chk("simempty_rd_valid", b5.valid, 1);
      b5.clr_err = 1'b1; step(); b5.clr_err = 1'b0;
      chk("simempty_udf_clr", b5.underflow, 0);

      // Reset mid-operation
      for (int i = 0; i < 5; i++) begin
         b5.wr_en = 1'b1; b5.din = 8'(8'h41 + i);
         step();
      end
      b5.din = 8'hCC; step();
      b5.wr_en = 1'b0;
      b5.rd_en = 1'b1; step(); step();
      b5.rd_en = 1'b0;
      chk("mid_level", b5.level, 3);
      chk("mid_ovf", b5.overflow, 1);
      chk("mid_dout_pre", b5.dout, 8'h42);
      rst5_n = 1'b0; step(); rst5_n = 1'b1;
      chk("mid_rst_level", b5.level, 0);
      chk("mid_rst_empty", b5.empty, 1);
      chk("mid_rst_valid", b5.valid, 0);
      chk("mid_rst_ovf", b5.overflow, 0);
      chk("mid_rst_dout", b5.dout, 0);
      b5.wr_en = 1'b1; b5.din = 8'h77; step(); b5.wr_en = 1'b0;
      b5.rd_en = 1'b1; step(); b5.rd_en = 1'b0;
      chk("post_rst_dout", b5.dout, 8'h77);
      chk("post_rst_valid", b5.valid, 1);
      b5.clr_err = 1'b1; b5.rd_en = 1'b1; step();
      b5.rd_en = 1'b0;
      chk("clr_vs_set_udf", b5.underflow, 1);
      step();
      b5.clr_err = 1'b0;
      chk("clr_udf", b5.underflow, 0);

      // Thresholds at DEPTH=10, AF=8, AE=2
      for (int n = 0; n <= 10; n++) begin
         chk("thr_fill_level", b10.level, n);
         chk("thr_fill_ae", b10.almost_empty, (n <= 2));
         chk("thr_fill_af", b10.almost_full, (n >= 8));
         chk("thr_fill_full", b10.full, (n == 10));
         if (n < 10) begin
            b10.wr_en = 1'b1; b10.din = 8'(n); step(); b10.wr_en = 1'b0;
         end
      end
      for (int n = 10; n >= 0; n--) begin
         chk("thr_drain_level", b10.level, n);
         chk("thr_drain_ae", b10.almost_empty, (n <= 2));
         chk("thr_drain_af", b10.almost_full, (n >= 8));
         chk("thr_drain_empty", b10.empty, (n == 0));
         if (n > 0) begin
            b10.rd_en = 1'b1; step(); b10.rd_en = 1'b0;
         end
      end

      // First-word-fall-through at DEPTH=4
      chk("fw_rst_valid", bf.valid, 0);
      chk("fw_rst_empty", bf.empty, 1);
      bf.wr_en = 1'b1; bf.din = 8'h5A; step(); bf.wr_en = 1'b0;
      chk("fw_first_dout", bf.dout, 8'h5A);
      chk("fw_first_valid", bf.valid, 1);
      step();
      chk("fw_hold_dout", bf.dout, 8'h5A);
      chk("fw_hold_valid", bf.valid, 1);
      bf.wr_en = 1'b1; bf.din = 8'h5B; step(); bf.wr_en = 1'b0;
      chk("fw_head_kept", bf.dout, 8'h5A);
      chk("fw_level2", bf.level, 2);
      bf.rd_en = 1'b1; step(); bf.rd_en = 1'b0;
      chk("fw_pop_dout", bf.dout, 8'h5B);
      chk("fw_pop_valid", bf.valid, 1);
      bf.rd_en = 1'b1; step(); bf.rd_en = 1'b0;
      chk("fw_last_valid", bf.valid, 0);
      chk("fw_last_empty", bf.empty, 1);
      chk("fw_udf_clean", bf.underflow, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
